// File: rtl/tdm_demux_if.sv
// Link-side bundle for the TDM demultiplexer: slot words arriving from the
// shared bus plus the per-channel results handed to the consumers.
// The parity sideband exists only when TDM_DEMUX_PARITY_EN is defined.
interface tdm_demux_if #(
  parameter int N = 4,
  parameter int W = 8
);
  logic           in_valid;
  logic           in_sof;
  logic [W-1:0]   in_data;
  logic [N*W-1:0] out_data;
  logic [N-1:0]   out_valid;
  logic           frame_done;
  logic           frame_err;
`ifdef TDM_DEMUX_PARITY_EN
  logic           in_parity;
  logic           parity_err;
`endif

  // Upstream side: drives slot words and observes the channel results
  modport master (
    output in_valid, in_sof, in_data,
`ifdef TDM_DEMUX_PARITY_EN
    output in_parity,
    input  parity_err,
`endif
    input  out_data, out_valid, frame_done, frame_err
  );

  // Demultiplexer side: consumes slot words and produces the channel results
  modport slave (
    input  in_valid, in_sof, in_data,
`ifdef TDM_DEMUX_PARITY_EN
    input  in_parity,
    output parity_err,
`endif
    output out_data, out_valid, frame_done, frame_err
  );
endinterface

// File: rtl/tdm_demux.sv
// Time-division demultiplexer: receive end of a slot-interleaved link.
// Words tagged with start-of-frame mark slot 0; following words fill slots
// 1..N-1 in order. Each word lands in its channel register one cycle after
// it is sampled, with a one-hot out_valid pulse naming the channel.
// Optional feature macro: TDM_DEMUX_PARITY_EN adds an even-parity check on
// every word; a bad word still consumes its slot but is not written.
module tdm_demux #(
  parameter int N = 4,
  parameter int W = 8
) (
  input logic        clk,
  input logic        rst,
  tdm_demux_if.slave bus
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N*W-1:0] out_data_q, out_data_d;
  logic [N-1:0]   out_valid_q, out_valid_d;
  logic           frame_done_q, frame_done_d;
  logic           frame_err_q, frame_err_d;
  logic           accept;
  logic [CW-1:0]  slot;
  logic           bad_parity;

`ifdef TDM_DEMUX_PARITY_EN
  logic parity_err_q, parity_err_d;

  // A word is bad when the sideband bit fails to make the total count even
  assign bad_parity = (bus.in_parity != (^bus.in_data));
`else
  assign bad_parity = 1'b0;
`endif

  // Next-state logic: decide which slot the incoming word fills and advance the frame tracker
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    out_data_d   = out_data_q;
    out_valid_d  = '0;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    accept       = 1'b0;
    slot         = '0;
`ifdef TDM_DEMUX_PARITY_EN
    parity_err_d = 1'b0;
`endif

    if (bus.in_valid) begin
      case (state_q)
        HUNT: begin
          if (bus.in_sof) begin
            accept  = 1'b1;
            slot    = '0;
            cnt_d   = CW'(1);
            state_d = RUN;
          end else begin
            frame_err_d  = 1'b1;
`ifdef TDM_DEMUX_PARITY_EN
            parity_err_d = bad_parity;
`endif
          end
        end
        RUN: begin
          if (bus.in_sof) begin
            frame_err_d = 1'b1;
            accept      = 1'b1;
            slot        = '0;
            cnt_d       = CW'(1);
          end else begin
            accept = 1'b1;
            slot   = cnt_q;
            if (cnt_q == CW'(N - 1)) begin
              frame_done_d = 1'b1;
              cnt_d        = '0;
              state_d      = HUNT;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        default: begin
          state_d = HUNT;
          cnt_d   = '0;
        end
      endcase
    end

    if (accept) begin
      if (!bad_parity) begin
        for (int k = 0; k < N; k++) begin
          if (slot == CW'(k)) begin
            out_data_d[k*W +: W] = bus.in_data;
            out_valid_d[k]       = 1'b1;
          end
        end
      end else begin
`ifdef TDM_DEMUX_PARITY_EN
        parity_err_d = 1'b1;
`endif
      end
    end
  end

  // State and output registers; reset discards any partial frame
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= HUNT;
      cnt_q        <= '0;
      out_data_q   <= '0;
      out_valid_q  <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
    end
  end

`ifdef TDM_DEMUX_PARITY_EN
  // Parity error pulse register, aligned with where out_valid would have fired
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= parity_err_d;
    end
  end

  assign bus.parity_err = parity_err_q;
`endif

  assign bus.out_data   = out_data_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.frame_done = frame_done_q;
  assign bus.frame_err  = frame_err_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Testbench for tdm_demux. A behavioural model predicts each cycle's outputs
// when the stimulus is driven and pushes them into a scoreboard queue; the
// entry is popped and compared once the DUT has registered that cycle.
// Build with TDM_DEMUX_PARITY_EN defined to exercise the parity sideband.
module tb_tdm_demux;

  localparam int N = 4;
  localparam int W = 8;

  typedef struct packed {
    logic [N*W-1:0] data;
    logic [N-1:0]   valid;
    logic           done;
    logic           err;
    logic           perr;
  } exp_t;

  logic clk;
  logic rst;

  tdm_demux_if #(.N(N), .W(W)) bus ();

  tdm_demux #(.N(N), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  exp_t           sb_q[$];
  int             checks;
  int             errors;
  int             done_seen;
  int             err_seen;
  int             perr_seen;
  int             valid_seen;

  logic [N*W-1:0] m_data;
  logic           m_hunt;
  int             m_cnt;

  // Free-running clock, 10 time units per period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic void modelWrite(input int k, input logic [W-1:0] d,
                                     input logic pbad, inout exp_t e);
    if (pbad) begin
      e.perr = 1'b1;
    end else begin
      m_data[k*W +: W] = d;
      e.valid[k]       = 1'b1;
    end
  endfunction

  // One clock cycle: drive inputs, predict, let the edge pass, then compare
  task automatic applyStimulus(input logic r, input logic v, input logic s,
                               input logic [W-1:0] d, input logic pbad);
    exp_t e;
    exp_t got;
    rst          = r;
    bus.in_valid = v;
    bus.in_sof   = s;
    bus.in_data  = d;
`ifdef TDM_DEMUX_PARITY_EN
    bus.in_parity = (^d) ^ pbad;
`endif
    e = '0;
    if (r) begin
      m_data = '0;
      m_hunt = 1'b1;
      m_cnt  = 0;
    end else if (v) begin
      if (m_hunt) begin
        if (s) begin
          modelWrite(0, d, pbad, e);
          m_cnt  = 1;
          m_hunt = 1'b0;
        end else begin
          e.err  = 1'b1;
          e.perr = pbad;
        end
      end else if (s) begin
        e.err = 1'b1;
        modelWrite(0, d, pbad, e);
        m_cnt = 1;
      end else begin
        modelWrite(m_cnt, d, pbad, e);
        if (m_cnt == N - 1) begin
          e.done = 1'b1;
          m_cnt  = 0;
          m_hunt = 1'b1;
        end else begin
          m_cnt++;
        end
      end
    end
    e.data = m_data;
    sb_q.push_back(e);

    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    checkOutput("out_data", 64'(bus.out_data), 64'(got.data));
    checkOutput("out_valid", 64'(bus.out_valid), 64'(got.valid));
    checkOutput("frame_done", 64'(bus.frame_done), 64'(got.done));
    checkOutput("frame_err", 64'(bus.frame_err), 64'(got.err));
    checkOutput("valid_onehot0", 64'($onehot0(bus.out_valid)), 64'(1));
`ifdef TDM_DEMUX_PARITY_EN
    checkOutput("parity_err", 64'(bus.parity_err), 64'(got.perr));
    if (bus.parity_err) perr_seen++;
`endif
    if (bus.frame_done) done_seen++;
    if (bus.frame_err) err_seen++;
    if (bus.out_valid != '0) valid_seen++;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic clearCounts();
    done_seen  = 0;
    err_seen   = 0;
    perr_seen  = 0;
    valid_seen = 0;
  endtask

  // Directed scenarios followed by a short random run through the model
  initial begin
    logic [W-1:0] words[4];
    logic         rv, rs, rp;
    logic [W-1:0] rd;

    checks       = 0;
    errors       = 0;
    m_data       = '0;
    m_hunt       = 1'b1;
    m_cnt        = 0;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_data  = '0;
`ifdef TDM_DEMUX_PARITY_EN
    bus.in_parity = 1'b0;
`endif
    clearCounts();

    $display("[TB] reset");
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("reset_data", 64'(bus.out_data), 64'h0);
    checkOutput("reset_valid", 64'(bus.out_valid), 64'h0);
    idle(1);

    $display("[TB] clean frame");
    clearCounts();
    words = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, (i == 0), words[i], 1'b0);
      checkOutput("clean_valid_bit", 64'(bus.out_valid), 64'(1 << i));
    end
    checkOutput("clean_done_aligned", 64'(bus.frame_done), 64'h1);
    idle(1);
    checkOutput("clean_data", 64'(bus.out_data), 64'h44332211);
    checkOutput("clean_done_count", 64'(done_seen), 64'd1);
    checkOutput("clean_err_count", 64'(err_seen), 64'd0);

    $display("[TB] gapped frame");
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    clearCounts();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, (i == 0), words[i], 1'b0);
      idle(3);
    end
    checkOutput("gap_data", 64'(bus.out_data), 64'h44332211);
    checkOutput("gap_done_count", 64'(done_seen), 64'd1);
    checkOutput("gap_valid_count", 64'(valid_seen), 64'd4);
    checkOutput("gap_err_count", 64'(err_seen), 64'd0);

    $display("[TB] early sof");
    clearCounts();
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hA1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'hA2, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hB1, 1'b0);
    checkOutput("early_err_pulse", 64'(bus.frame_err), 64'h1);
    checkOutput("early_ch0", 64'(bus.out_data[7:0]), 64'hB1);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'hB2, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'hB3, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'hB4, 1'b0);
    idle(1);
    checkOutput("early_data", 64'(bus.out_data), 64'hB4B3B2B1);
    checkOutput("early_err_count", 64'(err_seen), 64'd1);
    checkOutput("early_done_count", 64'(done_seen), 64'd1);

    $display("[TB] hunt garbage and mid-frame reset");
    clearCounts();
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h55, 1'b0);
    checkOutput("hunt_err", 64'(bus.frame_err), 64'h1);
    checkOutput("hunt_valid", 64'(bus.out_valid), 64'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h01, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h02, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("midreset_data", 64'(bus.out_data), 64'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h77, 1'b0);
    checkOutput("after_reset_err", 64'(bus.frame_err), 64'h1);
    checkOutput("hunt_err_count", 64'(err_seen), 64'd2);
    checkOutput("hunt_done_count", 64'(done_seen), 64'd0);

`ifdef TDM_DEMUX_PARITY_EN
    $display("[TB] parity");
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, (i == 0), words[i], 1'b0);
    clearCounts();
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h01, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h03, 1'b1);
    checkOutput("parity_pulse", 64'(bus.parity_err), 64'h1);
    checkOutput("parity_no_valid", 64'(bus.out_valid), 64'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h05, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h07, 1'b0);
    checkOutput("parity_done", 64'(bus.frame_done), 64'h1);
    idle(1);
    checkOutput("parity_data", 64'(bus.out_data), 64'h07052201);
    checkOutput("parity_count", 64'(perr_seen), 64'd1);
    checkOutput("parity_done_count", 64'(done_seen), 64'd1);
`endif

    $display("[TB] random traffic");
    for (int i = 0; i < 200; i++) begin
      rv = ($urandom_range(0, 3) != 0);
      rs = ($urandom_range(0, 4) == 0);
      rd = W'($urandom);
`ifdef TDM_DEMUX_PARITY_EN
      rp = ($urandom_range(0, 7) == 0);
`else
      rp = 1'b0;
`endif
      applyStimulus(($urandom_range(0, 49) == 0), rv, rs, rd, rp);
    end

    checkOutput("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Time-division demultiplexer, the receive end of a slot-interleaved link.
- An upstream mux serializes N channel words onto one W-bit bus; this block routes each word back to its own channel register.
- Uses frame-start tracking, a slot counter and error flagging.
- Sits between the shared link bus and N per-channel consumers.

Parameters:
- N, 4, number of channels/slots per frame; legal range N >= 2.
- W, 8, data width per slot in bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  a slot word is present this cycle.
- in_sof  input  1  start of frame; qualified by in_valid; marks slot 0.
- in_data  input  W  slot word.
- out_data  output  N*W  channel registers; channel k occupies bits [k*W +: W].
- out_valid  output  N  one-hot, one-cycle pulse; bit k set when channel k's register was updated.
- frame_done  output  1  one-cycle pulse when slot N-1 is accepted.
- frame_err  output  1  one-cycle pulse on a protocol violation.

Behaviour:
- Interface (already decided): single clock clk; reset rst is synchronous and active-high.
- Reset values:
  - out_data all 0; out_valid 0; frame_done 0; frame_err 0.
  - FSM in HUNT; slot counter 0.
- Reset mid-frame discards the partial frame. out_data clears to 0 on the cycle after rst is sampled high.
- Latency: in_data sampled at edge t appears on out_data with its out_valid bit set after edge t.
  - Registered, 1 cycle; no combinational path from in_* to out_*.
- Slot counter: width $clog2(N). Holds the index of the next expected slot.
- Cycles with in_valid=0:
  - Hold the state, the counter and out_data.
  - Drive out_valid, frame_done and frame_err to 0.
  - Gaps of any length are legal mid-frame.
- FSM state HUNT (between frames):
  - in_valid=1, in_sof=1: write channel 0, out_valid=1<<0, counter=1, go to RUN.
  - in_valid=1, in_sof=0: drop the word, pulse frame_err, stay in HUNT.
- FSM state RUN:
  - in_valid=1, in_sof=0: write channel[counter], pulse out_valid bit counter.
    - If counter==N-1: pulse frame_done, set counter to 0, go to HUNT.
    - Otherwise increment counter.
  - in_valid=1, in_sof=1 (early SOF, short frame): pulse frame_err and resynchronise.
    - Write channel 0, out_valid=1<<0, counter=1, stay in RUN.
- Channel registers that are not written in a cycle keep their value.
- Never increment the counter past N-1; non-power-of-2 N must not reach unused counts.
- At most one out_valid bit is high per cycle.
- frame_done and frame_err are never high in the same cycle.

Optional Feature:
- Macro: TDM_DEMUX_PARITY_EN.
- When defined, two extra ports are added:
  - in_parity input 1: even parity over in_data.
  - parity_err output 1: registered pulse, reset 0.
- A word with bad parity still consumes its slot: counter, FSM and frame_done behave as normal.
  - The channel register is not written.
  - Its out_valid bit stays 0.
  - parity_err pulses in the same cycle the out_valid would have.
- A bad-parity word in HUNT without SOF pulses both frame_err and parity_err.
- When undefined, neither port exists and no check is made.

Test Plan:
- Reset: hold rst=1 for 2 cycles, then release -> out_data=0, out_valid=0, frame_done=0, frame_err=0.
- Clean frame, N=4, W=8: words 0x11(sof),0x22,0x33,0x44 on 4 consecutive cycles -> out_valid 0001,0010,0100,1000 each 1 cycle later; out_data=0x44332211; frame_done pulses once, aligned with out_valid=1000.
- Gaps: same frame with in_valid=0 for 3 cycles between each word -> same final out_data 0x44332211, no extra pulses, frame_done once.
- Early SOF: 0xA1(sof),0xA2, then 0xB1(sof),0xB2,0xB3,0xB4 -> frame_err pulses once with the second SOF; channel 0 = 0xB1; final out_data=0xB4B3B2B1; one frame_done.
- HUNT garbage and mid-frame reset: 0x55 without SOF -> frame_err pulse, out_valid=0; then 0x01(sof),0x02, then rst for 1 cycle -> out_data=0; next 0x77 without SOF -> frame_err.
- Parity (TDM_DEMUX_PARITY_EN): frame with 0x03 in slot 1 carrying in_parity=1 -> parity_err pulses, out_valid bit 1 never set, channel 1 keeps its old value, frame_done still pulses after slot 3.
